// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data load/store
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_rdy,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pick_if, expired, idle, resp;

    assign idle    = rst_n && state_q == IDLE;
    assign resp    = state_q == RESP;
    assign pick_if = if_req && (!d_req || starve_q == SW'(STARVE_MAX));
    assign expired = TIMEOUT != 0 && tmo_q >= TW'(TIMEOUT);

    assign if_gnt    = idle && pick_if;
    assign d_gnt     = idle && d_req && !pick_if;
    assign if_rvalid = resp && !owner_q;
    assign d_rvalid  = resp && owner_q;
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;
    assign d_err     = d_rvalid && err_q;
    assign m_req     = state_q == ISSUE;
    assign m_we      = m_req && we_q;
    assign m_addr    = m_req ? addr_q : '0;
    assign m_wdata   = m_req ? wdata_q : '0;
    assign m_be      = m_req ? be_q : '0;

    // Arbitration, request latching, memory handshake and timeout sequencing
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        starve_d = starve_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            IDLE: if (if_req || d_req) begin
                state_d  = ISSUE;
                owner_d  = !pick_if;
                we_d     = pick_if ? 1'b0 : d_we;
                addr_d   = pick_if ? if_addr : d_addr;
                wdata_d  = pick_if ? '0 : d_wdata;
                be_d     = pick_if ? 4'hF : d_be;
                rdata_d  = '0;
                err_d    = 1'b0;
                tmo_d    = '0;
                starve_d = pick_if ? '0 : (if_req && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
            end
            ISSUE: begin
                tmo_d   = tmo_q + TW'(1);
                state_d = m_rdy ? (we_q ? RESP : WAIT_RSP) : expired ? RESP : ISSUE;
                err_d   = !m_rdy && expired;
            end
            WAIT_RSP: begin
                tmo_d   = tmo_q + TW'(1);
                state_d = (m_rvalid || expired) ? RESP : WAIT_RSP;
                rdata_d = m_rvalid ? m_rdata : '0;
                err_d   = !m_rvalid && expired;
            end
            RESP: state_d = IDLE;
        endcase
    end

    // State and latched request registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            starve_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule
